// File: rtl/au_div_4_seq.sv
// au_div_4_seq: sequential restoring divider, one quotient bit per clock with start/busy/done handshake
//  i_clk, i_rst          clock and synchronous active-high reset
//  i_start               request a division (accepted in IDLE or DONE)
//  i_dividend, i_divisor unsigned operands, latched on accept
//  o_busy                high while iterating
//  o_done                one-cycle pulse, results valid
//  o_quotient            quotient, held until the next completed operation
//  o_remainder           remainder, held until the next completed operation
//  o_div_zero            last operation had a zero divisor
module au_div_4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   t, dx, r_n;
    logic [WIDTH+1:0] sub;
    logic [WIDTH-1:0] q_n;
    logic             ge, last;
    // A restored remainder is always below the divisor, so its top bit never feeds the next step
    logic             unused_r_msb;
    assign unused_r_msb = r_q[WIDTH];
    assign t    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign dx   = {1'b0, d_q};
    // Extra carry bit of t + ~dx + 1 is the no-borrow flag, i.e. t >= dx
    assign sub  = {1'b0, t} + {1'b0, ~dx} + (WIDTH+2)'(1);
    assign ge   = sub[WIDTH+1];
    assign r_n  = ge ? sub[WIDTH:0] : t;
    assign q_n  = {q_q[WIDTH-2:0], ge};
    assign last = cnt_q == CW'(WIDTH-1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        if (state_q == CALC) begin
            r_d   = r_n;
            q_d   = q_n;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                quo_d   = q_n;
                rem_d   = r_n[WIDTH-1:0];
                dz_d    = 1'b0;
            end
        end else if (i_start) begin
            r_d     = '0;
            q_d     = i_dividend;
            d_d     = i_divisor;
            cnt_d   = '0;
            state_d = (i_divisor == '0) ? DONE : CALC;
            if (i_divisor == '0) begin
                quo_d = '1;
                rem_d = i_dividend;
                dz_d  = 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end
    assign o_busy      = state_q == CALC;
    assign o_done      = state_q == DONE;
    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;
    assign o_div_zero  = dz_q;
endmodule

// File: tb/tb_au_div_4_seq.sv
// tb_au_div_4_seq: directed and sweep checks of the sequential divider
module tb_au_div_4_seq;
    logic       i_clk = 1'b0;
    logic       i_rst, i_start;
    logic [3:0] i_dividend, i_divisor;
    logic       o_busy, o_done, o_div_zero;
    logic [3:0] o_quotient, o_remainder;
    int n_checks = 0;
    int n_fail   = 0;
    int excl_viol = 0;
    au_div_4_seq #(.WIDTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_busy(o_busy), .o_done(o_done),
        .o_quotient(o_quotient), .o_remainder(o_remainder), .o_div_zero(o_div_zero)
    );
    always #5 i_clk = ~i_clk;
    always @(negedge i_clk) if (o_busy && o_done) excl_viol++;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask
    task automatic do_op(input string tag, input int a, input int b, input int eq, input int er,
                         input int edz, input int elat);
        int lat;
        int nbusy;
        i_dividend = 4'(a);
        i_divisor  = 4'(b);
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        i_dividend = 4'($urandom);
        i_divisor  = 4'($urandom);
        lat   = 1;
        nbusy = 0;
        while (!o_done && lat < 20) begin
            nbusy += int'(o_busy);
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, nbusy, elat - 1);
        check({tag, "_q"}, int'(o_quotient), eq);
        check({tag, "_r"}, int'(o_remainder), er);
        check({tag, "_dz"}, int'(o_div_zero), edz);
        tick();
    endtask
    task automatic no_done_for(input string tag, input int n);
        int seen = 0;
        for (int k = 0; k < n; k++) begin
            seen += int'(o_done);
            tick();
        end
        check(tag, seen, 0);
    endtask
    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_dividend = '0;
        i_divisor = '0;
        tick();
        tick();
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_q", int'(o_quotient), 0);
        check("rst_r", int'(o_remainder), 0);
        check("rst_dz", int'(o_div_zero), 0);
        i_rst = 1'b0;
        tick();
        // 13/3 cycle by cycle
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("t1_busy_c%0d", c), int'(o_busy), 1);
            check($sformatf("t1_done_c%0d", c), int'(o_done), 0);
            tick();
        end
        check("t1_done", int'(o_done), 1);
        check("t1_busy5", int'(o_busy), 0);
        check("t1_q", int'(o_quotient), 4);
        check("t1_r", int'(o_remainder), 1);
        check("t1_dz", int'(o_div_zero), 0);
        tick();
        check("t1_idle_done", int'(o_done), 0);
        do_op("d15_1", 15, 1, 15, 0, 0, 5);
        do_op("d2_9", 2, 9, 0, 2, 0, 5);
        do_op("d0_5", 0, 5, 0, 0, 0, 5);
        do_op("d7_0", 7, 0, 15, 7, 1, 1);
        // start held with other operands while busy is ignored
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        tick();
        i_dividend = 4'd9;
        i_divisor  = 4'd2;
        for (int c = 1; c <= 3; c++) tick();
        tick();
        i_start = 1'b0;
        check("t4_done", int'(o_done), 1);
        check("t4_q", int'(o_quotient), 4);
        check("t4_r", int'(o_remainder), 1);
        tick();
        no_done_for("t4_no_second_done", 8);
        // back-to-back start from the done cycle
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        check("t5_done1", int'(o_done), 1);
        i_dividend = 4'd6;
        i_divisor  = 4'd4;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        check("t5_busy6", int'(o_busy), 1);
        check("t5_done6", int'(o_done), 0);
        check("t5_hold_q6", int'(o_quotient), 4);
        check("t5_hold_r6", int'(o_remainder), 1);
        for (int c = 7; c <= 9; c++) tick();
        check("t5_hold_q9", int'(o_quotient), 4);
        check("t5_busy9", int'(o_busy), 1);
        tick();
        check("t5_done10", int'(o_done), 1);
        check("t5_q", int'(o_quotient), 1);
        check("t5_r", int'(o_remainder), 2);
        tick();
        // reset mid-calculation abandons the operation
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("t6_busy", int'(o_busy), 0);
        check("t6_done", int'(o_done), 0);
        check("t6_q", int'(o_quotient), 0);
        check("t6_r", int'(o_remainder), 0);
        check("t6_dz", int'(o_div_zero), 0);
        no_done_for("t6_no_done", 8);
        do_op("d14_5", 14, 5, 2, 4, 0, 5);
        // all operand pairs against reference division
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op($sformatf("sw_%0d_%0d", a, b), a, b, b == 0 ? 15 : a / b,
                      b == 0 ? a : a % b, b == 0 ? 1 : 0, b == 0 ? 1 : 5);
                if (b != 0)
                    check($sformatf("sw_inv_%0d_%0d", a, b),
                          int'(int'(o_quotient) * b + int'(o_remainder) == a && int'(o_remainder) < b), 1);
            end
        end
        check("busy_done_excl", excl_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
